l2_req_rr_scheduler: RTL and testbench

Round-robin scheduler that shares the single L1->L2 request path among num_L1s L1-to-L2 request FIFOs. It replaces fixed-priority selection with fair, registered selection. It drives the datapath mux select (which_L1_out), the per-FIFO pop strobes and the L2-side valid. The select is held stable until L2 accepts, and a stall watchdog flags a hung L2.

---
 rtl/l2_req_rr_scheduler_pkg.sv | 35 +++
 rtl/l2_req_rr_scheduler_rr_pick.sv | 32 +++
 rtl/l2_req_rr_scheduler.sv | 147 ++++++++++++++
 tb/tb_l2_req_rr_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/l2_req_rr_scheduler_pkg.sv
// Shared definitions for the L1->L2 request round-robin scheduler:
// FSM state encoding and the rotating-priority search used by rr_pick.
package l2_req_rr_scheduler_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Widest requester vector the search function handles; callers zero-pad.
   localparam int unsigned RR_MAX_N = 64;

   // Find the first set, unmasked bit of req, starting just after last_ptr
   // and wrapping modulo n. found=0 when no candidate exists.
   function automatic void rr_next(
      input  logic [RR_MAX_N-1:0] req,
      input  logic [RR_MAX_N-1:0] mask,
      input  int unsigned         n,
      input  int unsigned         last_ptr,
      output logic                found,
      output int unsigned         winner
   );
      found  = 1'b0;
      winner = 0;
      for (int unsigned k = 1; k <= RR_MAX_N; k++) begin
         int unsigned idx;
         idx = (last_ptr + k) % n;
         if (k <= n && !found && req[idx] && !mask[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   endfunction

endpackage

// File: rtl/l2_req_rr_scheduler_rr_pick.sv
// Purely combinational rotating-priority finder: picks the next requester
// after last_ptr, ignoring any bit set in mask.
module l2_req_rr_scheduler_rr_pick
   import l2_req_rr_scheduler_pkg::*;
#(
   parameter int unsigned N = 2,
   parameter int unsigned W = 1
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] mask,
   input  logic [W-1:0] last_ptr,
   output logic         found,
   output logic [W-1:0] winner
);

   logic [RR_MAX_N-1:0] req_ext;
   logic [RR_MAX_N-1:0] mask_ext;
   int unsigned         winner_int;

   // Zero-pad to the search width and run the rotating search.
   always_comb begin
      req_ext          = '0;
      mask_ext         = '0;
      req_ext[N-1:0]   = req;
      mask_ext[N-1:0]  = mask;
      found            = 1'b0;
      winner_int       = 0;
      rr_next(req_ext, mask_ext, N, 32'(last_ptr), found, winner_int);
      winner           = W'(winner_int);
   end

endmodule

// File: rtl/l2_req_rr_scheduler.sv
// Round-robin scheduler sharing the L1->L2 request path among num_L1s FIFOs.
// Registered select held stable until L2 accepts; sticky stall watchdog.
// Optional build macro ARB_PERF_CNT_EN adds grant_cnt / wait_cnt counters.
module l2_req_rr_scheduler
   import l2_req_rr_scheduler_pkg::*;
#(
   parameter int unsigned num_L1s       = 2,
   parameter int unsigned num_L1s_log   = 1,
   parameter int unsigned timeout_width = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [num_L1s-1:0]       req,
   input  logic                     accept_L2,
   output logic                     valid_L2_out,
   output logic [num_L1s_log-1:0]   which_L1_out,
   output logic [num_L1s-1:0]       pop,
`ifdef ARB_PERF_CNT_EN
   output logic [32*num_L1s-1:0]    grant_cnt,
   output logic [31:0]              wait_cnt,
`endif
   output logic                     stall_err
);

   state_t                    state_reg, state_next;
   logic [num_L1s_log-1:0]    last_ptr_reg, last_ptr_next;
   logic [num_L1s_log-1:0]    which_reg, which_next;
   logic [timeout_width-1:0]  wd_reg, wd_next;
   logic                      stall_reg, stall_next;

   logic                      pop_fire;
   logic [num_L1s-1:0]        pick_mask;
   logic [num_L1s_log-1:0]    pick_last;
   logic                      pick_found;
   logic [num_L1s_log-1:0]    pick_winner;

   assign valid_L2_out = (state_reg == GRANT) && req[which_reg];
   assign pop_fire     = valid_L2_out && accept_L2;
   assign which_L1_out = which_reg;
   assign stall_err    = stall_reg;

   // One pop strobe per FIFO; only the granted one can fire.
   for (genvar gi = 0; gi < num_L1s; gi++) begin : g_pop
      assign pop[gi]       = pop_fire && (which_reg == num_L1s_log'(gi));
      // The popped FIFO's req is stale for a cycle, so hide it from re-arbitration.
      assign pick_mask[gi] = pop[gi];
   end

   // On a pop the search restarts after the popped index.
   assign pick_last = pop_fire ? which_reg : last_ptr_reg;

   l2_req_rr_scheduler_rr_pick #(
      .N (num_L1s),
      .W (num_L1s_log)
   ) u_rr_pick (
      .req      (req),
      .mask     (pick_mask),
      .last_ptr (pick_last),
      .found    (pick_found),
      .winner   (pick_winner)
   );

   // Next-state: grant, hold, zero-bubble switch, flush, and watchdog.
   always_comb begin
      state_next    = state_reg;
      last_ptr_next = last_ptr_reg;
      which_next    = which_reg;
      wd_next       = wd_reg;
      stall_next    = stall_reg;
      case (state_reg)
         IDLE: begin
            if (enable && pick_found) begin
               which_next = pick_winner;
               state_next = GRANT;
            end
         end
         GRANT: begin
            if (pop_fire) begin
               last_ptr_next = which_reg;
               wd_next       = '0;
               if (enable && pick_found) begin
                  which_next = pick_winner;
               end else begin
                  state_next = IDLE;
               end
            end else if (!req[which_reg]) begin
               state_next = IDLE;
            end else if (enable) begin
               // Presented but not accepted: count toward the stall timeout.
               if (wd_reg != '1) begin
                  wd_next = wd_reg + timeout_width'(1);
               end
               if (wd_next == '1) begin
                  stall_next = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         last_ptr_reg <= num_L1s_log'(num_L1s - 1);
         which_reg    <= '0;
         wd_reg       <= '0;
         stall_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         last_ptr_reg <= last_ptr_next;
         which_reg    <= which_next;
         wd_reg       <= wd_next;
         stall_reg    <= stall_next;
      end
   end

`ifdef ARB_PERF_CNT_EN
   logic [31:0] grant_cnt_reg [num_L1s];
   logic [31:0] wait_cnt_reg;

   for (genvar gi = 0; gi < num_L1s; gi++) begin : g_grant_cnt
      // Per-requester wrapping pop counter.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            grant_cnt_reg[gi] <= '0;
         end else if (pop[gi]) begin
            grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 32'd1;
         end
      end
      assign grant_cnt[gi*32 +: 32] = grant_cnt_reg[gi];
   end

   // Counts cycles a request is presented but L2 does not take it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt_reg <= '0;
      end else if (valid_L2_out && !accept_L2) begin
         wait_cnt_reg <= wait_cnt_reg + 32'd1;
      end
   end
   assign wait_cnt = wait_cnt_reg;
`endif

endmodule

// File: tb/tb_l2_req_rr_scheduler.sv
// Directed testbench for l2_req_rr_scheduler (num_L1s=2, timeout_width=3).
// Checks grant alternation, hold under stall, masked re-arbitration,
// watchdog, async reset, enable gating and, with ARB_PERF_CNT_EN, counters.
module tb_l2_req_rr_scheduler;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [1:0]  req;
   logic        accept_L2;
   logic        valid_L2_out;
   logic [0:0]  which_L1_out;
   logic [1:0]  pop;
   logic        stall_err;
`ifdef ARB_PERF_CNT_EN
   logic [63:0] grant_cnt;
   logic [31:0] wait_cnt;
`endif

   int n_checks;
   int n_pass;

   l2_req_rr_scheduler #(
      .num_L1s       (2),
      .num_L1s_log   (1),
      .timeout_width (3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .req          (req),
      .accept_L2    (accept_L2),
      .valid_L2_out (valid_L2_out),
      .which_L1_out (which_L1_out),
      .pop          (pop),
`ifdef ARB_PERF_CNT_EN
      .grant_cnt    (grant_cnt),
      .wait_cnt     (wait_cnt),
`endif
      .stall_err    (stall_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [0:0] exp_w;
      logic [1:0] oh;
      int         entries;
      logic [1:0] exp_pop;

      n_checks  = 0;
      n_pass    = 0;
      reset     = 1'b0;
      enable    = 1'b1;
      req       = 2'b00;
      accept_L2 = 1'b0;

      // Reset values
      #2;
      check("rst_valid", valid_L2_out, 0);
      check("rst_which", which_L1_out, 0);
      check("rst_pop",   pop,          0);
      check("rst_stall", stall_err,    0);
      step();
      step();
      reset = 1'b1;

      // Both requesting, L2 always accepting: zero-bubble alternation
      req = 2'b11; accept_L2 = 1'b1;
      #1;
      check("s1_idle_valid", valid_L2_out, 0);
      step();
      exp_w = 1'b0;
      for (int i = 0; i < 4; i++) begin
         oh = 2'b01 << exp_w;
         #1;
         check("s1_which", which_L1_out, exp_w);
         check("s1_pop",   pop,          oh);
         check("s1_valid", valid_L2_out, 1);
         step();
         exp_w = ~exp_w;
      end
      // Head drops without pop: flush
      req = 2'b00; accept_L2 = 1'b0;
      #1;
      check("s1_flush_valid", valid_L2_out, 0);
      check("s1_flush_pop",   pop,          0);
      step();

      // Held select while L2 stalls; req[1] rises mid-wait
      req = 2'b01;
      #1;
      check("s2_idle_valid", valid_L2_out, 0);
      step();
      for (int i = 0; i < 5; i++) begin
         if (i == 2) req = 2'b11;
         #1;
         check("s2_hold_which", which_L1_out, 0);
         check("s2_hold_pop",   pop,          0);
         check("s2_hold_valid", valid_L2_out, 1);
         step();
      end
      check("s2_no_stall", stall_err, 0);
      accept_L2 = 1'b1;
      #1;
      check("s2_pop", pop, 2'b01);
      step();
      req = 2'b00; accept_L2 = 1'b0;
      #1;
      check("s2_switch_which", which_L1_out, 1);
      check("s2_single_pop",   pop,          0);
      step();

      // Single requester with 3 entries: IDLE bubble between pops
      entries   = 3;
      accept_L2 = 1'b1;
      for (int c = 0; c < 7; c++) begin
         req     = (entries > 0) ? 2'b10 : 2'b00;
         exp_pop = (c == 1 || c == 3 || c == 5) ? 2'b10 : 2'b00;
         #1;
         check("s3_pop", pop, exp_pop);
         step();
         if (c == 1 || c == 3 || c == 5) entries--;
      end
      accept_L2 = 1'b0;

      // enable low blocks new grants
      enable = 1'b0; req = 2'b01;
      step();
      #1;
      check("en0_no_grant", valid_L2_out, 0);
      enable = 1'b1;
      step();

      // Watchdog: 7 stalled GRANT cycles set sticky stall_err
      check("s4_which", which_L1_out, 0);
      for (int k = 1; k <= 9; k++) begin
         #1;
         check("s4_stall", stall_err, (k >= 8) ? 1 : 0);
         step();
      end
      accept_L2 = 1'b1;
      #1;
      check("s4_pop",          pop,       2'b01);
      check("s4_stall_at_pop", stall_err, 1);
      step();
      req = 2'b00; accept_L2 = 1'b0;
      #1;
      check("s4_stall_sticky", stall_err, 1);

      // Async reset mid-GRANT
      req = 2'b01;
      step();
      accept_L2 = 1'b1;
      #1;
      check("s5_pre_pop", pop, 2'b01);
      #1;
      reset = 1'b0;
      #1;
      check("s5_rst_valid", valid_L2_out, 0);
      check("s5_rst_pop",   pop,          0);
      check("s5_rst_stall", stall_err,    0);
      check("s5_rst_which", which_L1_out, 0);
      step();
      req = 2'b11;
      step();
      reset = 1'b1;
      #1;
      check("s5_idle_valid", valid_L2_out, 0);
      step();

      // Alternation with 3 injected stall cycles, 10 pops total
      exp_w = 1'b0;
      for (int i = 0; i < 13; i++) begin
         accept_L2 = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
         oh        = accept_L2 ? (2'b01 << exp_w) : 2'b00;
         #1;
         check("s6_which", which_L1_out, exp_w);
         check("s6_pop",   pop,          oh);
         step();
         if (accept_L2) exp_w = ~exp_w;
      end
      req = 2'b00; accept_L2 = 1'b0;
      #1;
`ifdef ARB_PERF_CNT_EN
      check("s6_grant_cnt0", grant_cnt[31:0],  5);
      check("s6_grant_cnt1", grant_cnt[63:32], 5);
      check("s6_wait_cnt",   wait_cnt,         3);
`endif
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
